// File: rtl/vga_timing_generator.sv
// vga_timing_generator
// Free-running 640x480@60 Hz raster timing generator on the 25 MHz pixel clock.
// Produces hSync/vSync (active-low), the active-video qualifier, the current
// pixel coordinate and a one-cycle end-of-frame strobe (screenEnd).
// All outputs are registered and decoded from the next-state counter values,
// so each output always describes the counter state held in the same cycle.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frameCount
// output that increments each time the raster wraps back to (0,0).
module vga_timing_generator #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int V_FRONT = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33
) (
    input  logic       clk25,
    input  logic       reset,
    output logic       screenEnd,
    output logic       active,
    output logic       hSync,
    output logic       vSync,
    output logic [9:0] x,
    output logic [8:0] y
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frameCount
`endif
);

    localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

    // Thresholds sized to the 10-bit counters so every compare is width-matched.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(WIDTH);
    localparam logic [9:0] V_VIS      = 10'(HEIGHT);
    localparam logic [9:0] HS_START   = 10'(WIDTH + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(WIDTH + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(HEIGHT + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(HEIGHT + V_FRONT + V_SYNC);

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       screen_end_q, screen_end_d;
    logic       active_q, active_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       h_wrap;
    logic       frame_wrap;

    // Next raster position: hCount wraps at the end of each line, vCount steps on that wrap.
    always_comb begin
        h_wrap     = (hcount_q == H_LAST);
        frame_wrap = h_wrap && (vcount_q == V_LAST);
        hcount_d   = h_wrap ? '0 : hcount_q + 10'd1;
        vcount_d   = vcount_q;
        if (h_wrap) begin
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
        end
    end

    // Output decode from the next-state counters so registered outputs line up with the counters.
    always_comb begin
        active_d     = (hcount_d < H_VIS) && (vcount_d < V_VIS);
        hsync_d      = !((hcount_d >= HS_START) && (hcount_d < HS_END));
        vsync_d      = !((vcount_d >= VS_START) && (vcount_d < VS_END));
        x_d          = (hcount_d < H_VIS) ? hcount_d : '0;
        y_d          = (vcount_d < V_VIS) ? vcount_d[8:0] : '0;
        screen_end_d = (hcount_d == H_LAST) && (vcount_d == V_LAST);
    end

    // Counter and output registers; reset puts the raster at (0,0) immediately.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            hcount_q     <= '0;
            vcount_q     <= '0;
            screen_end_q <= 1'b0;
            active_q     <= 1'b1;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            screen_end_q <= screen_end_d;
            active_q     <= active_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            x_q          <= x_d;
            y_q          <= y_d;
        end
    end

    assign screenEnd = screen_end_q;
    assign active    = active_q;
    assign hSync     = hsync_q;
    assign vSync     = vsync_q;
    assign x         = x_q;
    assign y         = y_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame counter steps on the edge where both counters wrap back to zero.
    always_comb begin
        frame_cnt_d = frame_wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // Frame counter register, cleared by reset.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frameCount = frame_cnt_q;
`else
    logic unused_frame_wrap;
    assign unused_frame_wrap = frame_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator using a reduced raster so full frames fit
// in a short run. Expected outputs come from the cycle count since reset
// release: column = n mod H_TOTAL, row = (n div H_TOTAL) mod V_TOTAL.
module tb_vga_timing_generator;

    localparam int TW  = 16;
    localparam int TH  = 8;
    localparam int THF = 2;
    localparam int THS = 3;
    localparam int THB = 2;
    localparam int TVF = 2;
    localparam int TVS = 2;
    localparam int TVB = 1;
    localparam int HT  = TW + THF + THS + THB;
    localparam int VT  = TH + TVF + TVS + TVB;
    localparam int FT  = HT * VT;

    logic       clk25 = 1'b0;
    logic       reset = 1'b0;
    logic       screenEnd;
    logic       active;
    logic       hSync;
    logic       vSync;
    logic [9:0] x;
    logic [8:0] y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frameCount;
`endif

    int  vectors = 0;
    int  errs    = 0;
    int  n       = 0;
    bit  run     = 1'b0;
    int  pulses  = 0;
    int  last_pulse = -1;

    vga_timing_generator #(
        .WIDTH(TW), .HEIGHT(TH),
        .H_FRONT(THF), .H_SYNC(THS), .H_BACK(THB),
        .V_FRONT(TVF), .V_SYNC(TVS), .V_BACK(TVB)
    ) dut (
        .clk25     (clk25),
        .reset     (reset),
        .screenEnd (screenEnd),
        .active    (active),
        .hSync     (hSync),
        .vSync     (vSync),
        .x         (x),
        .y         (y)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frameCount(frameCount)
`endif
    );

    always #5 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_model(input string where);
        int h, v;
        h = n % HT;
        v = (n / HT) % VT;
        chk({where, ".x"},      32'(x),         (h < TW) ? h : 0);
        chk({where, ".y"},      32'(y),         (v < TH) ? v : 0);
        chk({where, ".active"}, 32'(active),    32'((h < TW) && (v < TH)));
        chk({where, ".hSync"},  32'(hSync),     32'(!(h >= TW + THF && h < TW + THF + THS)));
        chk({where, ".vSync"},  32'(vSync),     32'(!(v >= TH + TVF && v < TH + TVF + TVS)));
        chk({where, ".screenEnd"}, 32'(screenEnd), 32'(h == HT - 1 && v == VT - 1));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk({where, ".frameCount"}, 32'(frameCount), (n / FT) % 65536);
`endif
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic step(input string where);
        @(posedge clk25);
        if (run) n++;
        @(negedge clk25);
        check_model(where);
        if (screenEnd === 1'b1) begin
            if (last_pulse >= 0) chk({where, ".period"}, 32'(n - last_pulse), FT);
            last_pulse = n;
            pulses++;
        end
    endtask

    // Drop reset between clock edges and check outputs settle with no edge.
    task automatic async_reset(input string where);
        #2;
        reset = 1'b0;
        run   = 1'b0;
        n     = 0;
        last_pulse = -1;
        #1;
        check_model(where);
    endtask

    initial begin
        int len;
        reset = 1'b0;
        @(negedge clk25);
        check_model("rst_init");
        repeat (10) step("rst_hold");

        // Release between edges and run just over two full frames.
        reset = 1'b1;
        run   = 1'b1;
        pulses = 0;
        repeat (2 * FT + 5) step("frame");
        chk("pulse_count", 32'(pulses), 2);

        // Directed async reset in the middle of a vSync pulse.
        len = (TH + TVF) * HT + 4 - (n % FT) + FT;
        repeat (len) step("to_vsync");
        chk("in_vsync", 32'(vSync), 0);
        async_reset("async_vsync");
        repeat (3) step("rst_hold2");
        reset = 1'b1;
        run   = 1'b1;
        repeat (FT + 3) step("restart");

        // Randomized reset drop points with restarts.
        for (int k = 0; k < 4; k++) begin
            len = $urandom_range(2 * FT, 20);
            repeat (len) step("rand_run");
            async_reset("async_rand");
            repeat ($urandom_range(4, 1)) step("rand_hold");
            reset = 1'b1;
            run   = 1'b1;
        end
        repeat (FT + 2) step("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Free-running raster timing generator for a standard 640x480 @ 60 Hz VGA display, clocked by the 25 MHz pixel clock. Produces horizontal/vertical sync, an active-video qualifier, the current pixel coordinate and a one-cycle end-of-frame strobe. It sits between the pixel-clock divider and the pixel pipeline (image RAM address generation, sprite hit tests, colour mux); game logic uses `screenEnd` as its frame tick.

## Interface
Parameters:
- `WIDTH`, 640, visible pixels per line
- `HEIGHT`, 480, visible lines per frame
- `H_FRONT`, 16 / `H_SYNC`, 96 / `H_BACK`, 48, horizontal porch/sync widths in pixels
- `V_FRONT`, 10 / `V_SYNC`, 2 / `V_BACK`, 33, vertical porch/sync widths in lines

Ports:
- `clk25`  in  1  pixel clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `screenEnd`  out  1  high for one cycle on the last pixel clock of each frame
- `active`  out  1  high while the current pixel is in the visible region
- `hSync`  out  1  horizontal sync, active-low
- `vSync`  out  1  vertical sync, active-low
- `x`  out  10  current column, 0..WIDTH-1
- `y`  out  9  current row, 0..HEIGHT-1

## Operation
- H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK (525).
- Internal counters `hCount` (10 bit, 0..H_TOTAL-1) and `vCount` (10 bit, 0..V_TOTAL-1).
- Each cycle `hCount` increments; at H_TOTAL-1 it wraps to 0 and `vCount` increments; `vCount` wraps to 0 after V_TOTAL-1 (with `hCount` wrap).
- `active` = (hCount < WIDTH) && (vCount < HEIGHT).
- `hSync` = 0 iff WIDTH+H_FRONT <= hCount < WIDTH+H_FRONT+H_SYNC (656..751), else 1.
- `vSync` = 0 iff HEIGHT+V_FRONT <= vCount < HEIGHT+V_FRONT+V_SYNC (490..491), else 1.
- `x` = hCount when hCount < WIDTH, else 0; `y` = vCount[8:0] when vCount < HEIGHT, else 0. Never exceed visible range.
- `screenEnd` = 1 iff hCount == H_TOTAL-1 && vCount == V_TOTAL-1.
- No input other than reset influences timing; the generator never stalls.

## Timing
- All outputs are registers updated on the same `clk25` edge as the counters, decoded from the next-state counter values, so outputs always describe the counter state held in that cycle (zero latency, glitch-free).
- Reset (reset = 0), asynchronous: hCount = vCount = 0 immediately; outputs x = 0, y = 0, active = 1, hSync = 1, vSync = 1, screenEnd = 0. Held while reset low.
- First rising edge after reset release advances hCount to 1.
- Reset asserted mid-frame/mid-sync: counters and outputs return to reset values without waiting for a clock edge; sync pulses are truncated.
- Frame period exactly 420000 cycles; `screenEnd` is high exactly one cycle per frame, immediately preceding (x,y) = (0,0), active = 1.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: adds output `frameCount` (16 bit), reset 0, increments by 1 on the edge where both counters wrap to 0 (cycle after `screenEnd`), wraps 65535 -> 0.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset hold: reset = 0 for 10 cycles -> x = 0, y = 0, active = 1, hSync = 1, vSync = 1, screenEnd = 0 throughout.
- First line: release reset, count edges -> x = 639 active = 1 after 639 edges; active = 0 and x = 0 after 640; hSync low from edge 656 through 751, high at 752; y = 1, x = 0 after 800 edges.
- Vertical sync: vSync low exactly for lines 490-491 (cycles 392000..393599 after release), active = 0 for all of lines 480..524.
- Frame wrap: screenEnd high only in the cycle with hCount = 799, vCount = 524 (edge 419999); next cycle x = 0, y = 0, active = 1; second pulse exactly 420000 cycles later.
- Async reset mid-frame: drop reset at line 300, column 100 between clock edges -> outputs reach reset values with no clock edge; restart timing identical to first frame.
- With `VGA_TIMING_FRAME_CNT_EN`: frameCount = 0 after reset, 1 after first wrap, 2 after 840000 cycles.
